rst_seq_gen: RTL and testbench

- Synthesizable, parametrised reset/clock-enable sequencer.
- Generalises the fixed single-reset bench generator into N staged reset channels, a soft-reset handshake and a clock-enable strobe.
- Sits at the top of each core wrapper. Per-block resets are released in a fixed order from one system `rst`.
- Provides a divided `ce` strobe for slow sub-blocks.

---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/clk_en_div.sv | 40 ++++
 rtl/rst_seq_gen.sv | 147 ++++++++++++++
 tb/tb_rst_seq_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer and its clock-enable divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rst_seq_pkg;

   // Sequencer phases: all channels held, staged release, steady state.
   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      STAGE = 2'd1,
      RUN   = 2'd2
   } seq_state_t;

   // Width needed for a counter that must reach max_count (never below 1 bit).
   function automatic int cnt_width(input int max_count);
      if (max_count < 1) begin
         return 1;
      end
      return $clog2(max_count + 1);
   endfunction

   // Larger of two integers, used to size a counter shared by two phases.
   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/clk_en_div.sv
// Free-running clock-enable divider: one-cycle ce strobe every DIV cycles.
// Latency: first ce is high in the cycle after the DIV-th edge out of reset.
// Backpressure: none; counter only cleared by rst, DIV=1 gives constant ce.
module clk_en_div
   import rst_seq_pkg::*;
#(
   parameter int DIV = 4
)(
   input  logic clk,
   input  logic rst,
   output logic ce
);

   localparam int CW = cnt_width(DIV - 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   if (DIV < 1) begin : g_bad_div
      $error("clk_en_div: DIV must be >= 1");
   end

   logic [CW-1:0] cnt_q;
   logic          ce_q;

   // Count 0..DIV-1 and raise ce for the cycle following each wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ce_q  <= 1'b0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
         ce_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_q + CW'(1);
         ce_q  <= 1'b0;
      end
   end

   assign ce = ce_q;

endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: holds all channels, releases them bit 0 first, then runs.
// Latency: ch_rst[k] falls HOLD_CYCLES-1 + k*STAGE_GAP edges after reset; all outputs registered.
// Backpressure: soft_req accepted only in RUN (one-cycle soft_ack); otherwise ignored.
module rst_seq_gen
   import rst_seq_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int HOLD_CYCLES = 5,
   parameter int STAGE_GAP   = 2,
   parameter int CE_DIV      = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_req,
   output logic              soft_ack,
   output logic [NUM_CH-1:0] ch_rst,
   output logic              all_ready,
   output logic              busy,
   output logic              ce
);

   // One counter serves both the hold phase and the inter-stage gap.
   localparam int CNT_MAX = max_of(HOLD_CYCLES, STAGE_GAP) - 1;
   localparam int CW      = cnt_width(CNT_MAX);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("rst_seq_gen: NUM_CH must be >= 1");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("rst_seq_gen: HOLD_CYCLES must be >= 1");
   end
   if (STAGE_GAP < 1) begin : g_bad_gap
      $error("rst_seq_gen: STAGE_GAP must be >= 1");
   end
   if (CE_DIV < 1) begin : g_bad_ce_div
      $error("rst_seq_gen: CE_DIV must be >= 1");
   end

   seq_state_t        state_q;
   seq_state_t        state_d;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic [NUM_CH-1:0] ch_q;
   logic [NUM_CH-1:0] ch_d;
   logic [NUM_CH-1:0] ch_next_release;
   logic              ready_q;
   logic              busy_q;
   logic              ack_q;
   logic              ack_d;

   // Releasing the lowest still-asserted channel keeps the release order
   // strictly bit 0 upward; a channel can never drop ahead of a lower one.
   assign ch_next_release = ch_q & (ch_q - NUM_CH'(1));

   // Next-state logic: hold count, staged releases, soft-reset acceptance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      ack_d   = 1'b0;
      case (state_q)
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               ch_d    = ch_next_release;
               cnt_d   = '0;
               state_d = STAGE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STAGE: begin
            // Once the last channel has gone low, the next edge enters RUN.
            if (ch_q == '0) begin
               cnt_d   = '0;
               state_d = RUN;
            end else if (cnt_q == GAP_LAST) begin
               ch_d  = ch_next_release;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            // A request is honoured on an edge sampled while already in RUN.
            if (soft_req) begin
               ch_d    = '1;
               cnt_d   = '0;
               ack_d   = 1'b1;
               state_d = HOLD;
            end
         end
         default: begin
            ch_d    = '1;
            cnt_d   = '0;
            state_d = HOLD;
         end
      endcase
   end

   // State, counter and registered outputs; rst restores everything at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         ch_q    <= '1;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         ready_q <= (state_d == RUN);
         busy_q  <= (state_d != RUN);
         ack_q   <= ack_d;
      end
   end

   clk_en_div #(
      .DIV (CE_DIV)
   ) u_ce_div (
      .clk (clk),
      .rst (rst),
      .ce  (ce)
   );

   assign ch_rst    = ch_q;
   assign all_ready = ready_q;
   assign busy      = busy_q;
   assign soft_ack  = ack_q;

   // Released channels always form a contiguous run starting at bit 0.
   logic [NUM_CH-1:0] released;
   assign released = ~ch_q;

   a_release_order: assert property (@(posedge clk) disable iff (rst)
      (released & (released + NUM_CH'(1))) == '0);

   a_ready_busy: assert property (@(posedge clk) disable iff (rst)
      all_ready == !busy);

   a_ack_single: assert property (@(posedge clk) disable iff (rst)
      soft_ack |=> !soft_ack);

endmodule

// File: tb/tb_rst_seq_gen.sv
// Randomised scoreboard bench for rst_seq_gen: default instance plus a minimal one.
// Latency: expectations are queued at stimulus time and popped one cycle later.
// Backpressure: n/a; the monitor consumes one expectation per clock.
module tb_rst_seq_gen;

   localparam int H  = 5;
   localparam int G  = 2;
   localparam int N  = 4;
   localparam int D  = 4;
   localparam int HS = 1;
   localparam int GS = 2;
   localparam int NS = 1;
   localparam int DS = 1;

   typedef struct packed {
      logic [3:0] ch;
      logic       rdy;
      logic       bsy;
      logic       ack;
      logic       ce;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          soft_req;
   logic          soft_ack;
   logic [N-1:0]  ch_rst;
   logic          all_ready;
   logic          busy;
   logic          ce;
   logic          rst_s;
   logic          soft_req_s;
   logic          soft_ack_s;
   logic [NS-1:0] ch_rst_s;
   logic          all_ready_s;
   logic          busy_s;
   logic          ce_s;

   exp_t q_big[$];
   exp_t q_small[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   prev_b   = -1;
   int   cep_b    = -1;
   int   prev_s   = -1;
   int   cep_s    = -1;

   always #5 clk = ~clk;

   rst_seq_gen #(
      .NUM_CH      (N),
      .HOLD_CYCLES (H),
      .STAGE_GAP   (G),
      .CE_DIV      (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .soft_req  (soft_req),
      .soft_ack  (soft_ack),
      .ch_rst    (ch_rst),
      .all_ready (all_ready),
      .busy      (busy),
      .ce        (ce)
   );

   rst_seq_gen #(
      .NUM_CH      (NS),
      .HOLD_CYCLES (HS),
      .STAGE_GAP   (GS),
      .CE_DIV      (DS)
   ) dut_s (
      .clk       (clk),
      .rst       (rst_s),
      .soft_req  (soft_req_s),
      .soft_ack  (soft_ack_s),
      .ch_rst    (ch_rst_s),
      .all_ready (all_ready_s),
      .busy      (busy_s),
      .ce        (ce_s)
   );

   // Reference model in terms of "edges since the sequence origin":
   // prev is the index of the previous edge (-1 right after rst or an accepted
   // soft reset); channel b is out of reset once index >= H-1+b*G, and the
   // block is ready once index >= H+(N-1)*G. ce follows edges since rst mod d.
   task automatic model_step(input logic r, input logic s,
                             input int h, input int g, input int n, input int d,
                             input int prev_i, input int cep_i,
                             output int prev_o, output int cep_o,
                             output exp_t e);
      int k;
      int tr;
      e  = '0;
      tr = h + (n - 1) * g;
      if (r) begin
         prev_o = -1;
         cep_o  = -1;
         for (int b = 0; b < n; b++) e.ch[b] = 1'b1;
         e.bsy = 1'b1;
      end else begin
         cep_o = cep_i + 1;
         e.ce  = ((cep_o % d) == (d - 1));
         if (s && prev_i >= tr) begin
            prev_o = -1;
            for (int b = 0; b < n; b++) e.ch[b] = 1'b1;
            e.bsy = 1'b1;
            e.ack = 1'b1;
         end else begin
            k      = prev_i + 1;
            prev_o = k;
            for (int b = 0; b < n; b++) e.ch[b] = (k < h - 1 + b * g);
            e.rdy = (k >= tr);
            e.bsy = !e.rdy;
         end
      end
   endtask

   // Drive one cycle of stimulus and queue the response expected after the edge.
   task automatic cyc(input logic r, input logic s);
      exp_t e;
      logic ss;
      ss = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      rst        = r;
      soft_req   = s;
      rst_s      = r;
      soft_req_s = ss;
      model_step(r, s, H, G, N, D, prev_b, cep_b, prev_b, cep_b, e);
      q_big.push_back(e);
      model_step(r, ss, HS, GS, NS, DS, prev_s, cep_s, prev_s, cep_s, e);
      q_small.push_back(e);
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: one output set per clock, compared just after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_big.size() > 0) begin
            e = q_big.pop_front();
            chk("ch_rst",    ch_rst,              e.ch);
            chk("all_ready", {3'b000, all_ready}, {3'b000, e.rdy});
            chk("busy",      {3'b000, busy},      {3'b000, e.bsy});
            chk("soft_ack",  {3'b000, soft_ack},  {3'b000, e.ack});
            chk("ce",        {3'b000, ce},        {3'b000, e.ce});
         end
         if (q_small.size() > 0) begin
            e = q_small.pop_front();
            chk("small_ch_rst",    {3'b000, ch_rst_s},    e.ch);
            chk("small_all_ready", {3'b000, all_ready_s}, {3'b000, e.rdy});
            chk("small_busy",      {3'b000, busy_s},      {3'b000, e.bsy});
            chk("small_soft_ack",  {3'b000, soft_ack_s},  {3'b000, e.ack});
            chk("small_ce",        {3'b000, ce_s},        {3'b000, e.ce});
         end
      end
   end

   // Stimulus: directed scenarios first, then a randomised soak.
   initial begin
      rst        = 1'b1;
      soft_req   = 1'b0;
      rst_s      = 1'b1;
      soft_req_s = 1'b0;

      // Power-on sequence into RUN.
      repeat (5) cyc(1'b1, 1'b0);
      repeat (14) cyc(1'b0, 1'b0);

      // Single-cycle soft reset from RUN, then full re-sequence.
      cyc(1'b0, 1'b1);
      repeat (16) cyc(1'b0, 1'b0);

      // Soft request held from E0: ignored until the sequencer is in RUN.
      repeat (2) cyc(1'b1, 1'b0);
      repeat (13) cyc(1'b0, 1'b1);
      repeat (14) cyc(1'b0, 1'b0);

      // rst re-asserted mid-stage at E7, then a clean sequence.
      repeat (2) cyc(1'b1, 1'b0);
      repeat (7) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (14) cyc(1'b0, 1'b0);

      // rst and soft_req together in RUN: rst takes priority.
      cyc(1'b1, 1'b1);
      repeat (14) cyc(1'b0, 1'b0);

      // Randomised traffic: sparse rst, frequent soft requests.
      repeat (400) cyc($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0);

      repeat (3) @(negedge clk);
      n_checks++;
      if (q_big.size() != 0 || q_small.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d queued, expected 0/0", q_big.size(), q_small.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
